note_highway: RTL and testbench

- Downstream consumer of note_y_table in the rh_video_display path.
- Holds up to SLOTS on-screen notes. Each note's screen row is looked up once, at spawn, through note_y_table.
- Scrolls all notes left once per video frame and produces a registered per-pixel "note here" signal for the pixel mixer.
- Flags each note as it crosses the hit line (for scoring) and as it leaves the screen.

---
 rtl/rh_video_pkg.sv | 25 ++
 rtl/note_y_table.sv | 24 ++
 rtl/note_highway.sv | 158 +++++++++++++++
 tb/tb_note_highway.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rh_video_pkg.sv
// Shared video-path types: note codes, screen geometry and the on-screen note slot record.
package rh_video_pkg;

    localparam int NOTE_CODE_W = 4;
    localparam int SCREEN_W    = 1024;
    localparam int SCREEN_H    = 768;
    localparam int X_W         = 11;
    localparam int Y_W         = 10;

    typedef logic [NOTE_CODE_W-1:0] note_t;

    typedef struct packed {
        logic           valid;
        note_t          note;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } slot_t;

    // Half-open span test lo <= p < lo+len, widened to 12 bits so the upper bound never wraps.
    function automatic logic in_span(input logic [11:0] p, input logic [11:0] lo,
                                     input logic [11:0] len);
        return (p >= lo) && (p < lo + len);
    endfunction

endpackage

// File: rtl/note_y_table.sv
// Note code to screen row lookup; codes n and n+8 share a lane, eight lanes 40 rows apart.
module note_y_table
    import rh_video_pkg::*;
(
    input  note_t          note_i,
    output logic [Y_W-1:0] y_o
);

    always_comb begin
        y_o = 10'd48;
        case (note_i[2:0])
            3'd0: y_o = 10'd48;
            3'd1: y_o = 10'd88;
            3'd2: y_o = 10'd128;
            3'd3: y_o = 10'd168;
            3'd4: y_o = 10'd208;
            3'd5: y_o = 10'd248;
            3'd6: y_o = 10'd288;
            3'd7: y_o = 10'd328;
            default: y_o = 10'd48;
        endcase
    end

endmodule

// File: rtl/note_highway.sv
// Scrolling note highway: spawns notes into slots, scrolls them once per frame,
// reports hit-line crossings and expiries, and renders a registered per-pixel note mask.
module note_highway #(
    parameter int SLOTS       = 8,
    parameter int SCREEN_W    = 1024,
    parameter int NOTE_W      = 32,
    parameter int NOTE_H      = 16,
    parameter int SCROLL_STEP = 2,
    parameter int HIT_X       = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        spawn_valid,
    input  logic [3:0]  spawn_note,
    output logic        spawn_ready,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic        pixel_on,
    output logic [3:0]  pixel_note,
    output logic        hit_valid,
    output logic [3:0]  hit_note,
    output logic        expire_valid,
    output logic [3:0]  expire_note,
    output logic [4:0]  active_count,
    output logic        overrun
);
    import rh_video_pkg::*;

    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);
    localparam logic [X_W-1:0]   SPAWN_X  = X_W'(SCREEN_W - NOTE_W);
    localparam logic [X_W-1:0]   STEP_X   = X_W'(SCROLL_STEP);
    localparam logic [X_W-1:0]   HIT_LINE = X_W'(HIT_X);

    typedef enum logic {ST_IDLE, ST_SCROLL} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    slot_t            slots_q [SLOTS];
    logic [4:0]       count_q;
    logic             overrun_q;
    logic             hit_q, exp_q;
    note_t            hit_note_q, exp_note_q;
    logic             pix_on_q, pix_on_d;
    note_t            pix_note_q, pix_note_d;

    logic             free_any;
    logic [IDX_W-1:0] free_idx;
    logic [Y_W-1:0]   spawn_y;
    slot_t            cur;
    logic [X_W-1:0]   new_x;

    note_y_table u_y_table (
        .note_i (spawn_note),
        .y_o    (spawn_y)
    );

    // Lowest-index free slot: scan downward so the lowest hit is written last.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (!slots_q[k].valid) begin
                free_any = 1'b1;
                free_idx = IDX_W'(k);
            end
        end
    end

    assign spawn_ready = (state_q == ST_IDLE) && free_any && !frame_tick;
    assign cur         = slots_q[idx_q];
    assign new_x       = cur.x - STEP_X;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            hit_q      <= 1'b0;
            hit_note_q <= '0;
            exp_q      <= 1'b0;
            exp_note_q <= '0;
            for (int k = 0; k < SLOTS; k++) slots_q[k] <= '0;
        end else begin
            hit_q      <= 1'b0;
            hit_note_q <= '0;
            exp_q      <= 1'b0;
            exp_note_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_tick) begin
                        state_q <= ST_SCROLL;
                        idx_q   <= '0;
                    end else if (spawn_valid && free_any) begin
                        slots_q[free_idx] <= '{valid: 1'b1, note: spawn_note,
                                               x: SPAWN_X, y: spawn_y};
                        count_q <= count_q + 5'd1;
                    end
                end
                ST_SCROLL: begin
                    if (frame_tick) overrun_q <= 1'b1;
                    if (cur.valid) begin
                        if (cur.x < STEP_X) begin
                            slots_q[idx_q].valid <= 1'b0;
                            exp_q      <= 1'b1;
                            exp_note_q <= cur.note;
                            count_q    <= count_q - 5'd1;
                        end else begin
                            slots_q[idx_q].x <= new_x;
                            if (cur.x >= HIT_LINE && new_x < HIT_LINE) begin
                                hit_q      <= 1'b1;
                                hit_note_q <= cur.note;
                            end
                        end
                    end
                    if (idx_q == LAST_IDX) state_q <= ST_IDLE;
                    else                   idx_q   <= idx_q + 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pix_on_d   = 1'b0;
        pix_note_d = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (slots_q[k].valid &&
                in_span({1'b0, hcount}, {1'b0, slots_q[k].x}, 12'(NOTE_W)) &&
                in_span({2'b0, vcount}, {2'b0, slots_q[k].y}, 12'(NOTE_H))) begin
                pix_on_d   = 1'b1;
                pix_note_d = slots_q[k].note;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_on_q   <= 1'b0;
            pix_note_q <= '0;
        end else begin
            pix_on_q   <= pix_on_d;
            pix_note_q <= pix_note_d;
        end
    end

    assign pixel_on     = pix_on_q;
    assign pixel_note   = pix_note_q;
    assign hit_valid    = hit_q;
    assign hit_note     = hit_note_q;
    assign expire_valid = exp_q;
    assign expire_note  = exp_note_q;
    assign active_count = count_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_note_highway.sv
// Self-checking bench for note_highway: behavioural slot model, directed scenarios and random traffic.
module tb_note_highway;

    localparam int SLOTS = 8, SPAWN_X = 992, STEP = 2, HIT = 64, NW = 32, NH = 16;

    logic        clk = 1'b0, reset_n = 1'b0, frame_tick = 1'b0, spawn_valid = 1'b0;
    logic [3:0]  spawn_note = '0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        spawn_ready, pixel_on, hit_valid, expire_valid, overrun;
    logic [3:0]  pixel_note, hit_note, expire_note;
    logic [4:0]  active_count;

    always #5 clk = ~clk;

    note_highway dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .spawn_valid(spawn_valid), .spawn_note(spawn_note), .spawn_ready(spawn_ready),
        .hcount(hcount), .vcount(vcount), .pixel_on(pixel_on), .pixel_note(pixel_note),
        .hit_valid(hit_valid), .hit_note(hit_note),
        .expire_valid(expire_valid), .expire_note(expire_note),
        .active_count(active_count), .overrun(overrun)
    );

    int tests = 0, fails = 0;

    bit m_valid [SLOTS];
    int m_note [SLOTS], m_x [SLOTS], m_y [SLOTS];
    int m_scan, m_count;
    bit m_ovr, e_pon, e_hit, e_exp;
    int e_pnote, e_hnote, e_enote;

    int  frames, hits_seen, exps_seen, hit_frame, exp_frame, last_hit_note;
    bit  dut_ready;

    function automatic int ytab(input int n);
        return 48 + 40 * (n % 8);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit m_free_any();
        for (int k = 0; k < SLOTS; k++) if (!m_valid[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < SLOTS; k++) begin
            m_valid[k] = 0; m_note[k] = 0; m_x[k] = 0; m_y[k] = 0;
        end
        m_scan = -1; m_count = 0; m_ovr = 0;
        e_pon = 0; e_pnote = 0; e_hit = 0; e_hnote = 0; e_exp = 0; e_enote = 0;
        frames = 0; hits_seen = 0; exps_seen = 0; hit_frame = -1; exp_frame = -1;
        last_hit_note = -1;
    endtask

    task automatic model_advance(input bit ft, input bit sv, input int sn, input int hc, input int vc);
        bit rdy;
        rdy = (m_scan < 0) && m_free_any() && !ft;
        e_pon = 0; e_pnote = 0;
        for (int k = 0; k < SLOTS; k++) begin
            if (m_valid[k] && hc >= m_x[k] && hc < m_x[k] + NW &&
                vc >= m_y[k] && vc < m_y[k] + NH) begin
                e_pon = 1; e_pnote = m_note[k];
                break;
            end
        end
        e_hit = 0; e_hnote = 0; e_exp = 0; e_enote = 0;
        if (m_scan >= 0) begin
            int i, nx;
            i = m_scan;
            if (ft) m_ovr = 1;
            if (m_valid[i]) begin
                if (m_x[i] < STEP) begin
                    m_valid[i] = 0; e_exp = 1; e_enote = m_note[i]; m_count--;
                end else begin
                    nx = m_x[i] - STEP;
                    if (m_x[i] >= HIT && nx < HIT) begin e_hit = 1; e_hnote = m_note[i]; end
                    m_x[i] = nx;
                end
            end
            m_scan = (i == SLOTS - 1) ? -1 : i + 1;
        end else if (ft) begin
            m_scan = 0;
            frames++;
        end
        if (rdy && sv) begin
            for (int k = 0; k < SLOTS; k++) begin
                if (!m_valid[k]) begin
                    m_valid[k] = 1; m_note[k] = sn; m_x[k] = SPAWN_X; m_y[k] = ytab(sn);
                    m_count++;
                    break;
                end
            end
        end
    endtask

    task automatic step(input bit ft, input bit sv, input int sn, input int hc, input int vc);
        bit rdy;
        @(negedge clk);
        frame_tick = ft; spawn_valid = sv; spawn_note = 4'(sn);
        hcount = 11'(hc); vcount = 10'(vc);
        #1;
        rdy = (m_scan < 0) && m_free_any() && !ft;
        chk("spawn_ready", 32'(spawn_ready), 32'(rdy));
        dut_ready = spawn_ready;
        chk("pixel_on", 32'(pixel_on), 32'(e_pon));
        chk("pixel_note", 32'(pixel_note), 32'(e_pnote));
        chk("hit_valid", 32'(hit_valid), 32'(e_hit));
        if (e_hit) chk("hit_note", 32'(hit_note), 32'(e_hnote));
        chk("expire_valid", 32'(expire_valid), 32'(e_exp));
        if (e_exp) chk("expire_note", 32'(expire_note), 32'(e_enote));
        chk("active_count", 32'(active_count), 32'(m_count));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (hit_valid === 1'b1) begin hits_seen++; hit_frame = frames; last_hit_note = int'(hit_note); end
        if (expire_valid === 1'b1) begin exps_seen++; exp_frame = frames; end
        model_advance(ft, sv, sn, hc, vc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; frame_tick = 0; spawn_valid = 0;
        #1;
        chk("rst_pixel_on", 32'(pixel_on), 32'd0);
        chk("rst_pixel_note", 32'(pixel_note), 32'd0);
        chk("rst_hit", 32'(hit_valid), 32'd0);
        chk("rst_expire", 32'(expire_valid), 32'd0);
        chk("rst_count", 32'(active_count), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask

    task automatic probe(input string name, input int hc, input int vc, input int on, input int note);
        step(0, 0, 0, hc, vc);
        step(0, 0, 0, 0, 0);
        chk({name, "_on"}, 32'(pixel_on), 32'(on));
        if (on != 0) chk({name, "_note"}, 32'(pixel_note), 32'(note));
    endtask

    initial begin
        int lat, acc;
        bit done;
        model_reset();

        // First spawn lands in slot 0 at x=992 on lane y=88
        do_reset();
        step(0, 0, 0, 0, 0);
        chk("lit_ready_after_reset", 32'(dut_ready), 32'd1);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 992, 88);
        chk("lit_count_1", 32'(active_count), 32'd1);
        chk("lit_ready_still", 32'(dut_ready), 32'd1);
        step(0, 0, 0, 0, 0);
        chk("lit_spawn_pixel", 32'(pixel_on), 32'd1);
        chk("lit_spawn_pixel_note", 32'(pixel_note), 32'd1);

        // Nine back-to-back spawns: eight accepted, ninth stalls until the batch expires
        do_reset();
        acc = 0;
        for (int k = 0; k < 9; k++) begin
            step(0, 1, k, 0, 0);
            if (dut_ready) acc++;
        end
        chk("lit_accepted_8", 32'(acc), 32'd8);
        chk("lit_ninth_stalled", 32'(dut_ready), 32'd0);
        chk("lit_count_8", 32'(active_count), 32'd8);
        done = 0;
        for (int f = 0; f < 600 && !done; f++) begin
            step(1, 1, 9, 0, 0);
            for (int c = 0; c < 9 && !done; c++) begin
                step(0, 1, 9, 0, 0);
                if (dut_ready) done = 1;
            end
        end
        chk("lit_ninth_accepted", 32'(done), 32'd1);
        chk("lit_stall_frames", 32'(frames), 32'd497);
        chk("lit_expires_8", 32'(exps_seen), 32'd8);
        step(0, 0, 0, 0, 0);
        chk("lit_count_after_stall", 32'(active_count), 32'd1);

        // One note, frame every 20 cycles: single hit 64->62 and expiry at x=0
        do_reset();
        step(0, 1, 5, 0, 0);
        done = 0;
        for (int f = 0; f < 600 && !done; f++) begin
            step(1, 0, 0, 0, 0);
            idle(19);
            if (exps_seen > 0) done = 1;
        end
        chk("lit_hit_once", 32'(hits_seen), 32'd1);
        chk("lit_hit_note", 32'(last_hit_note), 32'd5);
        chk("lit_hit_frame", 32'(hit_frame), 32'd465);
        chk("lit_expire_frame", 32'(exp_frame), 32'd497);
        chk("lit_count_0", 32'(active_count), 32'd0);

        // Same-cycle frame_tick and spawn: tick wins, spawn accepted SLOTS+1 cycles later
        do_reset();
        step(1, 1, 3, 0, 0);
        chk("lit_tick_blocks_spawn", 32'(dut_ready), 32'd0);
        lat = 0; done = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            step(0, 1, 3, 0, 0);
            lat++;
            if (dut_ready) done = 1;
        end
        chk("lit_spawn_latency", 32'(lat), 32'(SLOTS + 1));
        step(0, 0, 0, 0, 0);
        chk("lit_no_overrun", 32'(overrun), 32'd0);

        // Second frame_tick 3 cycles into a scan sets sticky overrun; scan length unchanged
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        lat = 3; done = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            step(0, 0, 0, 0, 0);
            lat++;
            if (dut_ready) done = 1;
        end
        chk("lit_overrun_scan_len", 32'(lat), 32'(SLOTS + 1));
        chk("lit_overrun_set", 32'(overrun), 32'd1);
        idle(20);
        chk("lit_overrun_sticky", 32'(overrun), 32'd1);

        // Pixel boundaries: slot0 note 9 at x=100, slot1 note 1 at x=102, both on y=88
        do_reset();
        step(0, 1, 9, 0, 0);
        step(1, 0, 0, 0, 0); idle(8);
        step(0, 1, 1, 0, 0);
        for (int f = 0; f < 445; f++) begin
            step(1, 0, 0, 0, 0); idle(8);
        end
        probe("px_left_edge", 100, 88, 1, 9);
        probe("px_overlap", 110, 95, 1, 9);
        probe("px_slot1_only", 132, 88, 1, 1);
        probe("px_past_right", 134, 88, 0, 0);
        probe("px_before_left", 99, 88, 0, 0);
        probe("px_bottom_last", 100, 103, 1, 9);
        probe("px_below", 100, 104, 0, 0);

        // Random traffic with occasional short frame gaps and resets
        do_reset();
        begin
            int gap;
            gap = 10;
            for (int c = 0; c < 20000; c++) begin
                bit ft, sv;
                int sn, hc, vc, k;
                if ($urandom_range(0, 4999) == 0) begin
                    do_reset();
                    gap = 10;
                end
                gap--;
                ft = (gap <= 0);
                if (ft) gap = ($urandom_range(0, 15) == 0) ? int'($urandom_range(2, 8))
                                                          : int'($urandom_range(9, 14));
                sv = ($urandom_range(0, 3) == 0);
                sn = int'($urandom_range(0, 15));
                k  = int'($urandom_range(0, SLOTS - 1));
                if (m_valid[k] && $urandom_range(0, 3) != 0) begin
                    hc = m_x[k] + int'($urandom_range(0, 40)) - 4;
                    vc = m_y[k] + int'($urandom_range(0, 20)) - 2;
                    if (hc < 0) hc = 0;
                    if (hc > 2047) hc = 2047;
                    if (vc < 0) vc = 0;
                end else begin
                    hc = int'($urandom_range(0, 1100));
                    vc = int'($urandom_range(0, 767));
                end
                step(ft, sv, sn, hc, vc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
